// File: rtl/ttt_pkg.sv
// Shared definitions for the tick/tock token scheduler.
package ttt_pkg;

  localparam int TTT_NUM_PROCS = 8;

  // Processor index width; never narrower than one bit.
  function automatic int ttt_id_w(input int num_procs);
    return (num_procs > 1) ? $clog2(num_procs) : 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_DRAIN,
    ST_TOCK
  } ttt_state_t;

endpackage

// File: rtl/ttt_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping.
module ttt_rr_pick
  import ttt_pkg::*;
#(
  parameter int NUM_PROCS = TTT_NUM_PROCS,
  parameter int ID_W      = ttt_id_w(NUM_PROCS)
) (
  input  logic [NUM_PROCS-1:0] mask,
  input  logic [ID_W-1:0]      ptr,
  output logic                 found,
  output logic [ID_W-1:0]      idx
);

  localparam logic [ID_W:0] N_W = (ID_W + 1)'(NUM_PROCS);

  logic [ID_W:0] pos;

  // Walk offsets from ptr; the lowest offset with a set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int off = 0; off < NUM_PROCS; off++) begin
      pos = {1'b0, ptr} + (ID_W + 1)'(off);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && mask[pos[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ttt_token_scheduler.sv
// Tick/tock token scheduler: grants each requesting processor at most once per
// round in round-robin order, waits for the datapath to drain, then strobes tock.
//
// state    | meaning
// ---------|------------------------------------------------------------
// IDLE     | waiting for start
// SCAN     | pick next eligible processor from rr_ptr, or go drain
// ISSUE    | dp_valid held with dp_id until dp_ready
// DRAIN    | wait for dp_busy low
// TOCK     | one-cycle global strobe, clear served, count the round
module ttt_token_scheduler
  import ttt_pkg::*;
#(
  parameter int NUM_PROCS = TTT_NUM_PROCS,
  parameter int ID_W      = ttt_id_w(NUM_PROCS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_PROCS-1:0] token_req,
  output logic [NUM_PROCS-1:0] token_ack,
  output logic                 dp_valid,
  output logic [ID_W-1:0]      dp_id,
  input  logic                 dp_ready,
  input  logic                 dp_busy,
  output logic                 tock,
  output logic                 busy,
  output logic [7:0]           round_count
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCS - 1);

  ttt_state_t           state, state_next;
  logic [NUM_PROCS-1:0] served, served_next;
  logic [ID_W-1:0]      rr_ptr, rr_next;
  logic [ID_W-1:0]      id_next;
  logic                 valid_next;
  logic [7:0]           rc_next;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;

  ttt_rr_pick #(
    .NUM_PROCS(NUM_PROCS),
    .ID_W     (ID_W)
  ) u_pick (
    .mask (token_req & ~served),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // State and round bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      served      <= '0;
      rr_ptr      <= '0;
      dp_id       <= '0;
      dp_valid    <= 1'b0;
      round_count <= '0;
    end else begin
      state       <= state_next;
      served      <= served_next;
      rr_ptr      <= rr_next;
      dp_id       <= id_next;
      dp_valid    <= valid_next;
      round_count <= rc_next;
    end
  end

  // Next-state and strobe decode; strobes are forced low while reset is held.
  always_comb begin
    state_next  = state;
    served_next = served;
    rr_next     = rr_ptr;
    id_next     = dp_id;
    valid_next  = dp_valid;
    rc_next     = round_count;
    token_ack   = '0;
    tock        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (pick_found) begin
          id_next    = pick_idx;
          valid_next = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (dp_valid && dp_ready) begin
          if (!reset) token_ack = NUM_PROCS'(1) << dp_id;
          served_next[dp_id] = 1'b1;
          rr_next    = (dp_id == LAST_ID) ? '0 : dp_id + ID_W'(1);
          valid_next = 1'b0;
          state_next = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (!dp_busy) state_next = ST_TOCK;
      end
      ST_TOCK: begin
        tock        = !reset;
        served_next = '0;
        rc_next     = round_count + 8'd1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE) && !reset;

endmodule

// File: tb/tb_ttt_token_scheduler.sv
// Self-checking bench for ttt_token_scheduler with a grant-order reference model.
module tb_ttt_token_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] token_req = 8'h00;
  logic [7:0] token_ack;
  logic       dp_valid;
  logic [2:0] dp_id;
  logic       dp_ready = 1'b0;
  logic       dp_busy = 1'b0;
  logic       tock;
  logic       busy;
  logic [7:0] round_count;

  ttt_token_scheduler #(.NUM_PROCS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .token_req  (token_req),
    .token_ack  (token_ack),
    .dp_valid   (dp_valid),
    .dp_id      (dp_id),
    .dp_ready   (dp_ready),
    .dp_busy    (dp_busy),
    .tock       (tock),
    .busy       (busy),
    .round_count(round_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_rr = 0;
  int m_rc = 0;
  int exp_ids[$];

  // observations from one round
  int obs_ids[$];
  int obs_acks[$];
  int obs_tocks, obs_tock_cyc, obs_first_valid, obs_bad_ack, obs_unstable;
  int obs_valid_cycles, obs_last_xfer, obs_after_tock_bad;
  bit obs_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant order for one round: scan from the pointer, skip already-granted
  // processors, wrap; 'raise' joins the request set after the first grant.
  task automatic model_round(input logic [7:0] req, input logic [7:0] raise);
    logic [7:0] cur, granted;
    int ptr, idx;
    bit hit;
    exp_ids.delete();
    cur = req;
    granted = 8'h00;
    ptr = m_rr;
    do begin
      hit = 0;
      for (int off = 0; off < 8 && !hit; off++) begin
        idx = (ptr + off) % 8;
        if (cur[idx] && !granted[idx]) begin
          hit = 1;
          exp_ids.push_back(idx);
          granted[idx] = 1'b1;
          ptr = (idx + 1) % 8;
        end
      end
      if (hit && exp_ids.size() == 1) cur = cur | raise;
    end while (hit);
    m_rr = ptr;
    m_rc = (m_rc + 1) % 256;
  endtask

  // Expected tock cycle (start cycle = 0): SCAN,DRAIN,TOCK after the last
  // transfer, delayed until the first cycle dp_busy is low in DRAIN.
  function automatic int exp_tock(input int last_xfer, input int busy_cycles, input bit any);
    int first_low;
    if (!any) return 3;
    first_low = (busy_cycles > 0) ? last_xfer + busy_cycles + 1 : last_xfer + 1;
    return ((first_low > last_xfer + 2) ? first_low : last_xfer + 2) + 1;
  endfunction

  // Drive one round from start to the cycle after tock and record what happened.
  // hold >= 0: ready held low for 'hold' valid cycles per issue; else random ready.
  task automatic run_round(input logic [7:0] req, input int ready_pct, input int hold,
                           input int busy_cycles, input logic [7:0] raise);
    logic [7:0] drv, exp_ack;
    int busy_left, cur_hold;
    bit prev_v, prev_x, done;
    logic [2:0] prev_id;
    obs_ids.delete();
    obs_acks.delete();
    obs_tocks = 0; obs_tock_cyc = -1; obs_first_valid = -1; obs_bad_ack = 0;
    obs_unstable = 0; obs_valid_cycles = 0; obs_last_xfer = -1; obs_after_tock_bad = 0;
    obs_timeout = 0;
    drv = req; busy_left = 0; cur_hold = 0; prev_v = 0; prev_x = 0; prev_id = '0; done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      start = (cyc == 0);
      token_req = drv;
      if (hold >= 0) dp_ready = dp_valid && (cur_hold >= hold);
      else dp_ready = ($urandom_range(0, 99) < ready_pct);
      dp_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      #1;
      exp_ack = (dp_valid && dp_ready) ? (8'd1 << dp_id) : 8'd0;
      if (token_ack !== exp_ack) obs_bad_ack++;
      if (token_ack !== 8'd0) obs_acks.push_back(int'(token_ack));
      if (obs_tocks > 0) begin
        if (tock !== 1'b0 || busy !== 1'b0) obs_after_tock_bad++;
        done = 1;
      end else begin
        if (dp_valid === 1'b1) begin
          obs_valid_cycles++;
          if (obs_first_valid < 0) obs_first_valid = cyc;
          if (prev_v && !prev_x && dp_id !== prev_id) obs_unstable++;
          drv[dp_id] = 1'b0;
          if (dp_ready) begin
            obs_ids.push_back(int'(dp_id));
            obs_last_xfer = cyc;
            busy_left = busy_cycles;
            cur_hold = 0;
            if (obs_ids.size() == 1) drv = drv | raise;
          end else begin
            cur_hold++;
          end
        end
        prev_v = dp_valid;
        prev_id = dp_id;
        prev_x = dp_valid && dp_ready;
        if (tock === 1'b1) begin
          obs_tocks++;
          obs_tock_cyc = cyc;
        end
      end
      step();
    end
    if (!done) obs_timeout = 1;
    start = 1'b0; dp_ready = 1'b0; dp_busy = 1'b0; token_req = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; token_req = 8'h00; dp_ready = 1'b0; dp_busy = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    m_rr = 0;
    m_rc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; token_req = 8'hFF; dp_ready = 1'b1; dp_busy = 1'b0;
    step(); step();
    n_cmp++; if (dp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dp_valid: got %b want 0", dp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (tock !== 1'b0) begin n_bad++; $display("FAIL reset_tock: got %b want 0", tock); end
    n_cmp++; if (token_ack !== 8'h00) begin n_bad++; $display("FAIL reset_ack: got %h want 00", token_ack); end
    n_cmp++; if (round_count !== 8'd0) begin n_bad++; $display("FAIL reset_round_count: got %0d want 0", round_count); end
    n_cmp++; if (dp_id !== 3'd0) begin n_bad++; $display("FAIL reset_dp_id: got %0d want 0", dp_id); end
    reset = 1'b0; start = 1'b0; token_req = 8'h00; dp_ready = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_start: busy got %b want 0", busy); end
    m_rr = 0;
    m_rc = 0;
  endtask

  task automatic test_rotation();
    model_round(8'h0A, 8'h00);
    run_round(8'h0A, 100, -1, 0, 8'h00);
    n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL rot_timeout: no tock within budget"); end
    n_cmp++; if (obs_ids.size() != exp_ids.size()) begin n_bad++; $display("FAIL rot_count: got %0d grants want %0d", obs_ids.size(), exp_ids.size()); end
    for (int j = 0; j < exp_ids.size() && j < obs_ids.size(); j++) begin
      n_cmp++; if (obs_ids[j] != exp_ids[j]) begin n_bad++; $display("FAIL rot_id[%0d]: got %0d want %0d", j, obs_ids[j], exp_ids[j]); end
      n_cmp++; if (j < obs_acks.size() && obs_acks[j] != (1 << exp_ids[j])) begin n_bad++; $display("FAIL rot_ack[%0d]: got %h want %h", j, obs_acks[j], 1 << exp_ids[j]); end
    end
    n_cmp++; if (obs_acks.size() != exp_ids.size()) begin n_bad++; $display("FAIL rot_ack_count: got %0d want %0d", obs_acks.size(), exp_ids.size()); end
    n_cmp++; if (obs_first_valid != 2) begin n_bad++; $display("FAIL rot_latency: dp_valid first in cycle %0d want 2", obs_first_valid); end
    n_cmp++; if (obs_tocks != 1) begin n_bad++; $display("FAIL rot_tocks: got %0d want 1", obs_tocks); end
    n_cmp++; if (int'(round_count) != m_rc) begin n_bad++; $display("FAIL rot_round_count: got %0d want %0d", round_count, m_rc); end
    n_cmp++; if (obs_bad_ack != 0) begin n_bad++; $display("FAIL rot_ack_protocol: %0d bad cycles want 0", obs_bad_ack); end
  endtask

  task automatic test_backpressure();
    model_round(8'h20, 8'h00);
    run_round(8'h20, 0, 4, 0, 8'h00);
    n_cmp++; if (obs_ids.size() != 1 || obs_ids[0] != 5) begin n_bad++; $display("FAIL bp_ids: got %0d grants want one grant of 5", obs_ids.size()); end
    n_cmp++; if (obs_valid_cycles != 5) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 5", obs_valid_cycles); end
    n_cmp++; if (obs_acks.size() != 1 || obs_acks[0] != 32'h20) begin n_bad++; $display("FAIL bp_acks: got %0d acks want one of 20", obs_acks.size()); end
    n_cmp++; if (obs_unstable != 0) begin n_bad++; $display("FAIL bp_stable: %0d id changes want 0", obs_unstable); end
    n_cmp++; if (obs_bad_ack != 0) begin n_bad++; $display("FAIL bp_ack_protocol: %0d bad cycles want 0", obs_bad_ack); end
    n_cmp++; if (int'(round_count) != m_rc) begin n_bad++; $display("FAIL bp_round_count: got %0d want %0d", round_count, m_rc); end
  endtask

  task automatic test_fairness();
    int dups;
    logic [7:0] seen;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      model_round(8'hFF, 8'h00);
      run_round(8'hFF, 70, -1, 0, 8'h00);
      n_cmp++; if (obs_ids.size() != 8) begin n_bad++; $display("FAIL fair_r%0d_count: got %0d want 8", r, obs_ids.size()); end
      for (int j = 0; j < 8 && j < obs_ids.size(); j++) begin
        n_cmp++; if (obs_ids[j] != j || exp_ids[j] != j) begin n_bad++; $display("FAIL fair_r%0d_id[%0d]: got %0d want %0d", r, j, obs_ids[j], j); end
      end
      dups = 0;
      seen = 8'h00;
      foreach (obs_ids[j]) begin
        if (seen[obs_ids[j]]) dups++;
        seen[obs_ids[j]] = 1'b1;
      end
      n_cmp++; if (dups != 0) begin n_bad++; $display("FAIL fair_r%0d_repeat: %0d repeats want 0", r, dups); end
    end
  endtask

  task automatic test_drain();
    model_round(8'h41, 8'h00);
    run_round(8'h41, 100, -1, 6, 8'h00);
    n_cmp++; if (obs_tock_cyc != obs_last_xfer + 8) begin n_bad++; $display("FAIL drain_tock_cycle: got %0d want %0d", obs_tock_cyc, obs_last_xfer + 8); end
    n_cmp++; if (obs_tocks != 1 || obs_after_tock_bad != 0) begin n_bad++; $display("FAIL drain_tock_width: tocks %0d after-tock errors %0d want 1/0", obs_tocks, obs_after_tock_bad); end
    n_cmp++; if (obs_ids.size() != 2 || obs_ids[0] != exp_ids[0]) begin n_bad++; $display("FAIL drain_ids: got %0d grants want 2", obs_ids.size()); end
  endtask

  task automatic test_midround_raise();
    do_reset();
    model_round(8'h22, 8'h08);
    run_round(8'h22, 100, -1, 0, 8'h08);
    n_cmp++; if (obs_ids.size() != 3) begin n_bad++; $display("FAIL raise_count: got %0d want 3", obs_ids.size()); end
    for (int j = 0; j < 3 && j < obs_ids.size(); j++) begin
      n_cmp++; if (obs_ids[j] != exp_ids[j]) begin n_bad++; $display("FAIL raise_id[%0d]: got %0d want %0d", j, obs_ids[j], exp_ids[j]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] req, raise;
    int pct, bc, et;
    for (int r = 0; r < 20; r++) begin
      req = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      raise = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      pct = $urandom_range(30, 100);
      bc = $urandom_range(0, 3);
      model_round(req, raise);
      run_round(req, pct, -1, bc, raise);
      n_cmp++; if (obs_timeout) begin n_bad++; $display("FAIL rnd%0d_timeout: no tock within budget", r); end
      n_cmp++; if (obs_ids.size() != exp_ids.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d (req %h)", r, obs_ids.size(), exp_ids.size(), req); end
      for (int j = 0; j < exp_ids.size() && j < obs_ids.size(); j++) begin
        n_cmp++; if (obs_ids[j] != exp_ids[j]) begin n_bad++; $display("FAIL rnd%0d_id[%0d]: got %0d want %0d", r, j, obs_ids[j], exp_ids[j]); end
      end
      et = exp_tock(obs_last_xfer, bc, exp_ids.size() != 0);
      n_cmp++; if (obs_tock_cyc != et) begin n_bad++; $display("FAIL rnd%0d_tock_cycle: got %0d want %0d", r, obs_tock_cyc, et); end
      n_cmp++; if (obs_bad_ack != 0 || obs_unstable != 0) begin n_bad++; $display("FAIL rnd%0d_protocol: ack errs %0d unstable %0d want 0/0", r, obs_bad_ack, obs_unstable); end
      n_cmp++; if (int'(round_count) != m_rc) begin n_bad++; $display("FAIL rnd%0d_round_count: got %0d want %0d", r, round_count, m_rc); end
    end
  endtask

  task automatic test_empty_wrap();
    int bad_rounds;
    do_reset();
    bad_rounds = 0;
    for (int r = 0; r < 255; r++) begin
      model_round(8'h00, 8'h00);
      run_round(8'h00, 100, -1, 0, 8'h00);
      if (obs_timeout || obs_tock_cyc != 3 || obs_tocks != 1) bad_rounds++;
    end
    n_cmp++; if (bad_rounds != 0) begin n_bad++; $display("FAIL empty_rounds: %0d bad rounds want 0", bad_rounds); end
    n_cmp++; if (int'(round_count) != m_rc) begin n_bad++; $display("FAIL empty_count255: got %0d want %0d", round_count, m_rc); end
    model_round(8'h00, 8'h00);
    run_round(8'h00, 100, -1, 0, 8'h00);
    n_cmp++; if (obs_tock_cyc != 3) begin n_bad++; $display("FAIL empty_tock_cycle: got %0d want 3", obs_tock_cyc); end
    n_cmp++; if (int'(round_count) != m_rc) begin n_bad++; $display("FAIL empty_wrap: got %0d want %0d", round_count, m_rc); end
    n_cmp++; if (obs_ids.size() != 0) begin n_bad++; $display("FAIL empty_grants: got %0d want 0", obs_ids.size()); end
  endtask

  task automatic test_reset_mid_issue();
    bit seen_valid;
    model_round(8'h04, 8'h00);
    run_round(8'h04, 100, -1, 0, 8'h00);
    n_cmp++; if (obs_ids.size() != 1 || obs_ids[0] != 2) begin n_bad++; $display("FAIL rmid_setup: got %0d grants want one of 2", obs_ids.size()); end
    token_req = 8'h10; start = 1'b1; dp_ready = 1'b0;
    step();
    start = 1'b0;
    seen_valid = 0;
    for (int w = 0; w < 10 && !seen_valid; w++) begin
      if (dp_valid === 1'b1) seen_valid = 1;
      else step();
    end
    n_cmp++; if (!seen_valid) begin n_bad++; $display("FAIL rmid_wait_valid: dp_valid never rose within 10 cycles"); end
    reset = 1'b1; dp_ready = 1'b1;
    #1;
    n_cmp++; if (token_ack !== 8'h00 || tock !== 1'b0) begin n_bad++; $display("FAIL rmid_ack_in_reset: ack %h tock %b want 00/0", token_ack, tock); end
    step();
    reset = 1'b0; dp_ready = 1'b0; token_req = 8'h00;
    #1;
    n_cmp++; if (dp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_dp_valid: got %b want 0", dp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (round_count !== 8'd0) begin n_bad++; $display("FAIL rmid_round_count: got %0d want 0", round_count); end
    step();
    m_rr = 0;
    m_rc = 0;
    model_round(8'h81, 8'h00);
    run_round(8'h81, 100, -1, 0, 8'h00);
    n_cmp++; if (obs_ids.size() != 2 || obs_ids[0] != exp_ids[0] || obs_ids[1] != exp_ids[1]) begin n_bad++; $display("FAIL rmid_restart_order: got %0d grants first %0d want 0 then 7", obs_ids.size(), (obs_ids.size() > 0) ? obs_ids[0] : -1); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_fairness();
    test_drain();
    test_midround_raise();
    test_random();
    test_empty_wrap();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ttt_token_scheduler.md
TTT_TOKEN_SCHEDULER -- requirements
Module: ttt_token_scheduler

Interface
REQ-001 Parameter NUM_PROCS, default 8: number of token processors sharing the token datapath.
REQ-002 Parameter ID_W, default $clog2(NUM_PROCS): width of the processor index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse that begins one tick/tock round; honoured only in IDLE.
REQ-006 token_req  input  NUM_PROCS  per-processor "token pending" level.
REQ-007 token_ack  output  NUM_PROCS  one-hot pulse; token of processor i taken this cycle.
REQ-008 dp_valid  output  1  token issue to the datapath is valid.
REQ-009 dp_id  output  ID_W  index of the processor whose token is issued.
REQ-010 dp_ready  input  1  datapath accepts the token; transfer when dp_valid && dp_ready.
REQ-011 dp_busy  input  1  datapath still processing issued tokens.
REQ-012 tock  output  1  one-cycle global update strobe that ends a round.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 round_count  output  8  number of completed rounds, modulo 256.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, ISSUE, DRAIN and TOCK, all registered.
REQ-016 IDLE -> SCAN on start; start in any other state SHALL be ignored.
REQ-017 In SCAN, eligible = token_req & ~served; the winner is the first set bit at or after rr_ptr, wrapping modulo NUM_PROCS.
REQ-018 SCAN -> ISSUE if eligible is non-zero, registering dp_id = winner and dp_valid = 1; otherwise SCAN -> DRAIN.
REQ-019 In ISSUE, dp_valid and dp_id SHALL stay stable until dp_ready, even if token_req[dp_id] drops.
REQ-020 On the ISSUE transfer cycle: token_ack = onehot(dp_id), combinational, that cycle only; at the edge served[dp_id] is set, rr_ptr = (dp_id+1) mod NUM_PROCS, dp_valid = 0, state -> SCAN.
REQ-021 Each processor SHALL be granted at most once per round; a request raised mid-round before the processor's turn SHALL be served in that round.
REQ-022 DRAIN -> TOCK on the first cycle with dp_busy low, including the cycle DRAIN is entered.
REQ-023 In TOCK, tock = 1 for exactly one cycle; at the edge served is cleared, round_count increments (255 -> 0) and state -> IDLE.
REQ-024 rr_ptr SHALL persist across rounds and change only on transfers.
REQ-025 Latency: start at edge k gives SCAN in cycle k+1; dp_valid is high from cycle k+2 if any request is eligible.
REQ-026 A start with token_req = 0 SHALL produce the path SCAN, DRAIN, TOCK, with tock in cycle k+3 if dp_busy is low.
REQ-027 token_ack SHALL be zero whenever dp_valid && dp_ready is false.

Reset
REQ-028 While reset is high, state SHALL be IDLE and served, rr_ptr, dp_id and round_count SHALL be 0.
REQ-029 While reset is high, dp_valid, tock, busy and token_ack SHALL be 0.
REQ-030 Reset mid-round SHALL abandon the round with no tock, no token_ack, and dp_valid low from the next cycle.

Structure
REQ-031 Package ttt_pkg SHALL hold the NUM_PROCS default, the ID_W derivation and the FSM state enum type.
REQ-032 Round-robin selection SHALL live in the combinational sub-module ttt_rr_pick (inputs mask and ptr; outputs found and idx), instantiated once.

Verification
REQ-033 Three-request rotation: token_req = 8'b0000_1010, rr_ptr = 0, dp_ready = 1, start -> dp_id 1 then 3; token_ack 0x02 then 0x08; one tock; round_count = 1.
REQ-034 Backpressure: one request on proc 5, dp_ready low for 4 cycles -> dp_valid high with dp_id = 5 for 5 cycles, token_ack only on the ready cycle.
REQ-035 Fairness: all 8 requesting over two rounds -> round 1 issues 0..7, round 2 issues 0..7 again, and no id repeats within a round.
REQ-036 Drain hold: dp_busy high for 6 cycles after the last transfer -> tock is delayed until the first cycle dp_busy is low, then stays high for 1 cycle.
REQ-037 Empty round and wrap: token_req = 0 with round_count preloaded to 255 via 255 rounds, then start -> tock in cycle k+3 and round_count = 0.
REQ-038 Reset mid-ISSUE: reset asserted while dp_valid = 1 -> next cycle dp_valid = 0, busy = 0, round_count = 0, and a later start begins from rr_ptr = 0.
